// File: rtl/arb_pkg.sv
// Shared constants for the arbitrated multiplexer: mode encodings and the
// index-width helper used to size channel selects.
package arb_pkg;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Ceiling log2, never less than 1 so a select field always has a bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant selection: round-robin from a start pointer, or fixed
// priority with the lowest index winning.
module rr_grant
    import arb_pkg::*;
#(
    parameter int NUM = 4,
    localparam int SEL_W = clog2(NUM)
) (
    input  logic [NUM-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             mode,
    output logic [SEL_W-1:0] grant,
    output logic             any_valid
);

    always_comb begin
        int start;
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        start     = (mode == ARB_FIXED) ? 0 : int'(ptr);
        idx       = 0;
        // Scan from the far end backwards so the closest requester to the
        // start position is the last one written and therefore wins.
        for (int k = NUM - 1; k >= 0; k--) begin
            idx = start + k;
            if (idx >= NUM) begin
                idx = idx - NUM;
            end
            if (req[idx]) begin
                grant     = SEL_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-input valid/ready multiplexer with a registered output stage and
// run-time selectable round-robin or fixed-priority arbitration.
module arb_mux_n
    import arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    localparam int SEL_W = clog2(NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [NUM*WIDTH-1:0] in_data,
    input  logic [NUM-1:0]       in_valid,
    output logic [NUM-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_sel
);

    logic [WIDTH-1:0] chan [NUM];
    logic [SEL_W-1:0] ptr_reg;
    logic [WIDTH-1:0] data_reg;
    logic [SEL_W-1:0] sel_reg;
    logic             valid_reg;
    logic [SEL_W-1:0] grant;
    logic             any_valid;
    logic             load;

    rr_grant #(
        .NUM(NUM)
    ) u_grant (
        .req      (in_valid),
        .ptr      (ptr_reg),
        .mode     (mode),
        .grant    (grant),
        .any_valid(any_valid)
    );

    assign load = !valid_reg || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM; gi++) begin : g_ch
            assign chan[gi]     = in_data[gi*WIDTH +: WIDTH];
            // Reset gates the accept so no source sees a handshake it loses.
            assign in_ready[gi] = load && any_valid && !rst && (grant == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg   <= '0;
            data_reg  <= '0;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (load) begin
            if (any_valid) begin
                data_reg  <= chan[grant];
                sel_reg   <= grant;
                valid_reg <= 1'b1;
                if (mode == ARB_RR) begin
                    // Explicit wrap so non-power-of-two NUM never lands on a
                    // nonexistent channel.
                    ptr_reg <= (grant == SEL_W'(NUM - 1)) ? '0 : grant + SEL_W'(1);
                end
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = data_reg;
    assign out_sel   = sel_reg;
    assign out_valid = valid_reg;

endmodule
